// File: rtl/data_mem_ctrl.sv
// Data memory controller: byte/half/word loads and stores on a single-port
// word memory, fixed one-cycle response latency, optional clear sweep
// after reset before any request is accepted.
module data_mem_ctrl #(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 12,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] sweep_cnt_reg;
  logic             req_ready_reg;
  logic             init_done_reg;

  // Word storage; each word is four byte lanes so stores can merge per lane.
  logic [3:0][7:0]  mem [DEPTH];
  logic [31:0]      rd_word_reg;

  logic             resp_valid_reg;
  logic             resp_err_reg;
  logic             resp_load_reg;
  logic [1:0]       resp_size_reg;
  logic [1:0]       resp_lane_reg;
  logic             resp_uns_reg;

  logic             accept;
  logic             legal;
  logic [IDX_W-1:0] req_idx;
  logic [3:0]       req_be;
  logic [3:0][7:0]  req_lane_data;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [3:0][7:0]  wr_data;

  assign accept  = req_valid & req_ready_reg;
  assign req_idx = req_addr[ADDR_W-1:2];

  // FSM: clear sweep in INIT (or skip it), then stay in RUN; outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      sweep_cnt_reg <= '0;
      req_ready_reg <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          if (CLEAR_ON_RESET == 0 || sweep_cnt_reg == LAST_IDX) begin
            state_reg     <= RUN;
            req_ready_reg <= 1'b1;
            init_done_reg <= 1'b1;
          end else begin
            sweep_cnt_reg <= sweep_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg     <= RUN;
          req_ready_reg <= 1'b1;
          init_done_reg <= 1'b1;
        end
      endcase
    end
  end

  // Alignment / size legality and byte enables of the incoming request.
  always_comb begin
    legal  = 1'b0;
    req_be = 4'b0000;
    case (req_size)
      SZ_BYTE: begin
        legal  = 1'b1;
        req_be = 4'b0001 << req_addr[1:0];
      end
      SZ_HALF: begin
        legal  = ~req_addr[0];
        req_be = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        legal  = (req_addr[1:0] == 2'b00);
        req_be = 4'b1111;
      end
      default: begin
        legal  = 1'b0;
        req_be = 4'b0000;
      end
    endcase
  end

  // Replicate right-aligned store data onto every lane it could land in.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign req_lane_data[gi] = (req_size == SZ_BYTE) ? req_wdata[7:0] :
                                 (req_size == SZ_HALF) ? req_wdata[8*(gi%2) +: 8] :
                                                         req_wdata[8*gi +: 8];
    end
  endgenerate

  // Single write port shared by the clear sweep and legal stores.
  always_comb begin
    if (state_reg == INIT && CLEAR_ON_RESET != 0) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_cnt_reg;
      wr_be   = 4'b1111;
      wr_data = '0;
    end else begin
      wr_en   = accept & req_we & legal;
      wr_idx  = req_idx;
      wr_be   = req_be;
      wr_data = req_lane_data;
    end
  end

  // Memory write with per-lane enables; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][b] <= wr_data[b];
      end
    end
  end

  // Registered read of the addressed word for accepted loads.
  always_ff @(posedge clk) begin
    if (accept && !req_we) rd_word_reg <= mem[req_idx];
  end

  // Response bookkeeping: one pulse per accepted request, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_load_reg  <= 1'b0;
      resp_size_reg  <= 2'b00;
      resp_lane_reg  <= 2'b00;
      resp_uns_reg   <= 1'b0;
    end else begin
      resp_valid_reg <= accept;
      resp_err_reg   <= accept & ~legal;
      resp_load_reg  <= accept & ~req_we & legal;
      if (accept) begin
        resp_size_reg <= req_size;
        resp_lane_reg <= req_addr[1:0];
        resp_uns_reg  <= req_unsigned;
      end
    end
  end

  // Lane select and sign/zero extension; zero unless a legal load responds.
  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    byte_sel   = rd_word_reg[{resp_lane_reg, 3'b000} +: 8];
    half_sel   = resp_lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    resp_rdata = 32'h0;
    if (resp_load_reg) begin
      case (resp_size_reg)
        SZ_BYTE: resp_rdata = {{24{~resp_uns_reg & byte_sel[7]}}, byte_sel};
        SZ_HALF: resp_rdata = {{16{~resp_uns_reg & half_sel[15]}}, half_sel};
        default: resp_rdata = rd_word_reg;
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign init_done  = init_done_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl at DEPTH=16: expected responses are
// queued when a request is driven and compared when resp_valid fires.
module tb_data_mem_ctrl;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 6;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              init_done;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];
  bit          mon_en = 1'b0;
  logic [32:0] mon_exp;
  string       mon_name;

  data_mem_ctrl #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Response monitor on the falling edge: pop and compare, or check idle zeros.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp rdata=%h err=%b required no response", resp_rdata, resp_err);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_name = name_q.pop_front();
          if ({resp_err, resp_rdata} !== mon_exp) begin
            errors++;
            $display("FAIL %s rdata=%h err=%b required rdata=%h err=%b",
                     mon_name, resp_rdata, resp_err, mon_exp[31:0], mon_exp[32]);
          end else begin
            $display("txn %s rdata=%h err=%b ok", mon_name, resp_rdata, resp_err);
          end
        end
      end else if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs valid=%b rdata=%h err=%b required 0/0/0", resp_valid, resp_rdata, resp_err);
      end
    end
  end

  // Drive one request for one cycle and queue its expected response.
  task automatic send(input logic we, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input string name);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready req_ready=%b required 1", name, req_ready);
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    name_q.push_back(name);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Let outstanding responses arrive, bounded.
  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d required 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // Count cycles from reset release until req_ready rises; drops any held request early.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 10) req_valid = 1'b0;
    end while (req_ready !== 1'b1 && n < 100);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = SZ_W;
    req_unsigned = 1'b0; req_wdata = '0;
    #2;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || init_done !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b done=%b valid=%b required 0/0/0", req_ready, init_done, resp_valid);
    end
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL sweep_cycles got=%0d required %0d", n, DEPTH);
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done got=%b required 1", init_done);
    end
    send(1'b0, 6'h3C, SZ_W, 1'b0, 32'h0, 32'h0000_0000, 1'b0, "ld_w_3c_cleared");
    drain();
  endtask

  task automatic test_extend();
    send(1'b1, 6'h10, SZ_W, 1'b0, 32'h8000_00F1, 32'h0,          1'b0, "st_w_10");
    send(1'b0, 6'h10, SZ_B, 1'b0, 32'h0,         32'hFFFF_FFF1, 1'b0, "ld_b_s_10");
    send(1'b0, 6'h10, SZ_B, 1'b1, 32'h0,         32'h0000_00F1, 1'b0, "ld_b_u_10");
    send(1'b0, 6'h12, SZ_H, 1'b0, 32'h0,         32'hFFFF_8000, 1'b0, "ld_h_s_12");
    send(1'b0, 6'h12, SZ_H, 1'b1, 32'h0,         32'h0000_8000, 1'b0, "ld_h_u_12");
    send(1'b0, 6'h13, SZ_B, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0, "ld_b_s_13");
    send(1'b0, 6'h10, SZ_W, 1'b1, 32'h0,         32'h8000_00F1, 1'b0, "ld_w_10");
    drain();
  endtask

  task automatic test_byte_merge();
    send(1'b1, 6'h20, SZ_W, 1'b0, 32'h1122_3344, 32'h0,          1'b0, "st_w_20");
    send(1'b1, 6'h21, SZ_B, 1'b0, 32'hFFFF_FFAB, 32'h0,          1'b0, "st_b_21");
    send(1'b0, 6'h20, SZ_W, 1'b0, 32'h0,         32'h1122_AB44, 1'b0, "ld_w_20_merged");
    send(1'b1, 6'h22, SZ_H, 1'b0, 32'h1234_BEEF, 32'h0,          1'b0, "st_h_22");
    send(1'b0, 6'h20, SZ_W, 1'b0, 32'h0,         32'hBEEF_AB44, 1'b0, "ld_w_20_half");
    send(1'b0, 6'h20, SZ_H, 1'b0, 32'h0,         32'hFFFF_AB44, 1'b0, "ld_h_s_20");
    drain();
  endtask

  task automatic test_errors();
    send(1'b1, 6'h04, SZ_W, 1'b0, 32'h0102_0304, 32'h0,          1'b0, "st_w_04");
    send(1'b1, 6'h06, SZ_W, 1'b0, 32'hFFFF_FFFF, 32'h0,          1'b1, "st_w_06_misal");
    send(1'b0, 6'h05, SZ_H, 1'b0, 32'h0,         32'h0,          1'b1, "ld_h_05_misal");
    send(1'b1, 6'h05, SZ_H, 1'b0, 32'hFFFF_FFFF, 32'h0,          1'b1, "st_h_05_misal");
    send(1'b1, 6'h04, SZ_R, 1'b0, 32'hFFFF_FFFF, 32'h0,          1'b1, "st_rsv_04");
    send(1'b0, 6'h08, SZ_R, 1'b0, 32'h0,         32'h0,          1'b1, "ld_rsv_08");
    send(1'b0, 6'h04, SZ_W, 1'b0, 32'h0,         32'h0102_0304, 1'b0, "ld_w_04_unchanged");
    send(1'b0, 6'h07, SZ_B, 1'b0, 32'h0,         32'h0000_0001, 1'b0, "ld_b_07");
    send(1'b0, 6'h06, SZ_H, 1'b1, 32'h0,         32'h0000_0102, 1'b0, "ld_h_u_06");
    drain();
  endtask

  // Address 0x40 aliases to word 0 with a 6-bit address, so word 0 is used.
  task automatic test_back_to_back();
    send(1'b1, 6'h00, SZ_W, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, "b2b_st_w_00");
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pulse1 resp_valid=%b required 1", resp_valid);
    end
    send(1'b0, 6'h00, SZ_W, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, "b2b_ld_w_00");
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pulse2 resp_valid=%b required 1", resp_valid);
    end
    send(1'b1, 6'h01, SZ_B, 1'b0, 32'h0000_005A, 32'h0,          1'b0, "b2b_st_b_01");
    send(1'b0, 6'h00, SZ_W, 1'b0, 32'h0,         32'hCAFE_5A0D, 1'b0, "b2b_ld_w_00_merged");
    drain();
  endtask

  // Reset right after a load is accepted must kill its response at once.
  task automatic test_abort();
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h00; req_size = SZ_W;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        req_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs valid=%b rdata=%h err=%b ready=%b done=%b required all 0",
               resp_valid, resp_rdata, resp_err, req_ready, init_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL abort_sweep_cycles got=%0d required %0d", n, DEPTH);
    end
  endtask

  // Reset at sweep cycle 5 restarts the full sweep; a held request is ignored.
  task automatic test_reset_mid_sweep();
    int n;
    send(1'b1, 6'h08, SZ_W, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, "st_w_08");
    drain();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL midsweep_reset ready=%b done=%b required 0/0", req_ready, init_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h08; req_size = SZ_W;
    wait_ready(n);
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL resweep_cycles got=%0d required %0d", n, DEPTH);
    end
    send(1'b0, 6'h08, SZ_W, 1'b0, 32'h0, 32'h0000_0000, 1'b0, "ld_w_08_recleared");
    drain();
  endtask

  initial begin
    test_reset();
    test_extend();
    test_byte_merge();
    test_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
